axi_wr_burst_gen: RTL and testbench
===================================

Name: axi_wr_burst_gen

Overview:
Downstream consumer of the byte/beat alignment calculator. Takes one write command (aligned start address, total beat count, first/last-beat strobes) and drives the AXI4 write channels. Splits the command into bursts of at most MAX_BURST beats, never crossing a 4 KB boundary. Counts B responses and signals completion.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data bus width (bits); STRB_W = DATA_W/8
BEATS_W, 10, width of total beat count (max 1023 beats)
MAX_BURST, 16, max beats per AXI burst (1..256)
MAX_OUTST, 15, max outstanding bursts awaiting B

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted (high only in IDLE)
cmd_addr  in  ADDR_W  start address, aligned to STRB_W
cmd_beats  in  BEATS_W  total beats; 0 is illegal and is dropped
cmd_first_strb  in  STRB_W  strobe for the first beat
cmd_last_strb  in  STRB_W  strobe for the last beat
s_data  in  DATA_W  write data stream
s_valid  in  1  data valid
s_ready  out  1  data ready; equals wready && W-active
m_awaddr  out  ADDR_W  burst address
m_awlen  out  8  beats-1
m_awsize  out  3  log2(STRB_W), constant
m_awburst  out  2  constant 2'b01 (INCR)
m_awvalid  out  1
m_awready  in  1
m_wdata  out  DATA_W  = s_data (combinational pass-through)
m_wstrb  out  STRB_W
m_wlast  out  1
m_wvalid  out  1  = s_valid && W-active
m_wready  in  1
m_bresp  in  2
m_bvalid  in  1
m_bready  out  1  constant 1 once out of reset
done  out  1  one-cycle pulse when the command is fully acknowledged
err  out  1  sticky per command: any bresp != 0; cleared on the next cmd accept

Behaviour:
- Reset (async assert, sync release): state IDLE. awvalid, wvalid, s_ready, done, err = 0. Address and counters = 0. bready = 0 during reset, 1 afterwards.
- Accept a command when cmd_valid && cmd_ready. If cmd_beats == 0: pulse done the next cycle, issue no traffic.
- States:
  - IDLE -> ADDR on accept.
  - ADDR: register burst length len = min(remaining, MAX_BURST, (4096 - addr[11:0]) / STRB_W). Assert awvalid with awaddr = cur_addr and awlen = len-1.
    - awvalid stays asserted with stable awaddr/awlen until awready.
    - If outstanding == MAX_OUTST, hold awvalid low.
    - On the handshake: outstanding++, go to DATA.
  - DATA: pass beats through. Beat count advances on wvalid && wready.
    - wstrb = cmd_first_strb on the command's first beat, cmd_last_strb on its last beat, first & last if cmd_beats == 1, otherwise all ones.
    - wlast is high on beat len-1 of the current burst.
    - After the wlast handshake: cur_addr += len*STRB_W and remaining -= len. Go to ADDR if remaining != 0, else RESP.
  - RESP: wait until outstanding == 0, then pulse done for one cycle and return to IDLE. cmd_ready rises in the cycle after done.
- B handling: each bvalid (bready = 1) decrements outstanding. If bvalid arrives in the same cycle as an aw handshake, outstanding is unchanged.
- Any bresp != 0 sets err. err holds until the next command accept.
- Latency: cmd accept -> awvalid is 1 cycle. AW handshake -> W-active is the next cycle. AW and W of one burst never overlap.
- No data stall handling beyond AXI: a W beat needs both s_valid and wready. s_data beats outside DATA are not consumed.
- 4 KB rule: a burst that would cross addr[11:0] wrap is cut at the boundary. The next burst starts exactly at the 4 KB boundary.
- Remaining counter is BEATS_W bits; the address counter wraps modulo 2^ADDR_W with no error.
- Reset mid-command: all state is discarded and no done pulse is issued. The AXI side sees valids drop immediately, which the system accepts.

Test Plan:
- addr=0x1000, beats=40, first=0xFF, last=0x0F, MAX_BURST=16 -> bursts at 0x1000/0x1080/0x1100 with awlen 15/15/7. Beat 39 has wstrb=0x0F; wlast on beats 15, 31, 39. One done pulse after the 3rd B.
- addr=0x1FF0, beats=6 -> burst1 at 0x1FF0 with awlen=1, burst2 at 0x2000 with awlen=3. No burst crosses the 4 KB boundary.
- beats=1, first=0xF0, last=0x3C -> single burst with awlen=0, wstrb=0x30, wlast=1, done after B.
- Random awready/wready/s_valid stalls at 50% on beats=33 -> awaddr/awlen stable while awvalid is high, 33 W handshakes, data order preserved.
- bresp=2'b10 on the second of three bursts -> err=1 at done. err is cleared on the next accept.
- Assert rst during the DATA phase of beats=20 -> outputs return to reset values at once, no done pulse, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_wr_burst_gen.sv
// AXI4 write burst generator: splits one aligned write command into INCR bursts
// of at most MAX_BURST beats that never cross a 4 KB boundary, and tracks B responses.
module axi_wr_burst_gen #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BEATS_W   = 10,
  parameter int MAX_BURST = 16,
  parameter int MAX_OUTST = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [BEATS_W-1:0]    cmd_beats,
  input  logic [DATA_W/8-1:0]   cmd_first_strb,
  input  logic [DATA_W/8-1:0]   cmd_last_strb,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic                  done,
  output logic                  err
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int STRB_LOG = $clog2(STRB_W);
  localparam int LEN_W    = (BEATS_W > 13) ? BEATS_W : 13;
  localparam int OUT_W    = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]  cur_addr;
  logic [BEATS_W-1:0] remaining;
  logic [LEN_W-1:0]   burst_len;
  logic [LEN_W-1:0]   beat_cnt;
  logic [LEN_W-1:0]   next_len;
  logic [LEN_W-1:0]   rem_ext;
  logic [LEN_W-1:0]   bytes_to_4k;
  logic [LEN_W-1:0]   beats_to_4k;
  logic [STRB_W-1:0]  first_strb;
  logic [STRB_W-1:0]  last_strb;
  logic               first_pending;
  logic [OUT_W-1:0]   outstanding;
  logic               bready_q;
  logic               err_q;
  logic               accept;
  logic               aw_hs;
  logic               w_hs;
  logic               b_hs;
  logic               w_active;
  logic               burst_end;
  logic               cmd_last_beat;

  assign rem_ext     = LEN_W'(remaining);
  assign bytes_to_4k = LEN_W'(13'd4096 - {1'b0, cur_addr[11:0]});
  assign beats_to_4k = bytes_to_4k >> STRB_LOG;

  assign accept        = cmd_valid && (state == IDLE);
  assign w_active      = (state == DATA);
  assign aw_hs         = m_awvalid && m_awready;
  assign w_hs          = w_active && s_valid && m_wready;
  assign b_hs          = m_bvalid && bready_q;
  assign burst_end     = (beat_cnt == burst_len - LEN_W'(1));
  assign cmd_last_beat = burst_end && (rem_ext == burst_len);

  // Burst length is the tightest of remaining beats, MAX_BURST and room to the 4 KB edge.
  always_comb begin
    next_len = rem_ext;
    if (next_len > LEN_W'(MAX_BURST)) next_len = LEN_W'(MAX_BURST);
    if (next_len > beats_to_4k)       next_len = beats_to_4k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (cmd_beats == '0) ? RESP : ADDR;
      ADDR: if (aw_hs) state_nxt = DATA;
      DATA: if (w_hs && burst_end) state_nxt = (rem_ext != burst_len) ? ADDR : RESP;
      RESP: if (outstanding == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    m_awvalid = (state == ADDR) && (outstanding != OUT_W'(MAX_OUTST));
    m_awaddr  = cur_addr;
    m_awlen   = 8'(next_len - LEN_W'(1));
    m_awsize  = 3'(STRB_LOG);
    m_awburst = 2'b01;
    m_wdata   = s_data;
    m_wvalid  = s_valid && w_active;
    s_ready   = m_wready && w_active;
    m_wlast   = w_active && burst_end;
    m_wstrb   = '1;
    if (first_pending) m_wstrb = m_wstrb & first_strb;
    if (cmd_last_beat) m_wstrb = m_wstrb & last_strb;
    m_bready  = bready_q;
    done      = (state == RESP) && (outstanding == '0);
    err       = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr      <= '0;
      remaining     <= '0;
      burst_len     <= '0;
      beat_cnt      <= '0;
      first_strb    <= '0;
      last_strb     <= '0;
      first_pending <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr      <= cmd_addr;
        remaining     <= cmd_beats;
        first_strb    <= cmd_first_strb;
        last_strb     <= cmd_last_strb;
        first_pending <= 1'b1;
      end
      if (aw_hs) begin
        burst_len <= next_len;
        beat_cnt  <= '0;
      end
      if (w_hs) begin
        first_pending <= 1'b0;
        if (burst_end) begin
          cur_addr  <= cur_addr + ADDR_W'(burst_len << STRB_LOG);
          remaining <= remaining - BEATS_W'(burst_len);
        end else begin
          beat_cnt <= beat_cnt + LEN_W'(1);
        end
      end
    end
  end

  // A B response landing with an AW handshake leaves the outstanding count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (aw_hs && !b_hs) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (b_hs && !aw_hs && (outstanding != '0)) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      bready_q <= 1'b0;
    end else begin
      bready_q <= 1'b1;
      if (accept)                        err_q <= 1'b0;
      else if (b_hs && (m_bresp != 2'b00)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// Directed bench for axi_wr_burst_gen: a burst/beat list model built from the command
// is compared against every AW and W handshake, with B responses returned after each wlast.
module tb_axi_wr_burst_gen;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [9:0]  cmd_beats;
  logic [7:0]  cmd_first_strb;
  logic [7:0]  cmd_last_strb;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic        done;
  logic        err;

  axi_wr_burst_gen dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_beats(cmd_beats), .cmd_first_strb(cmd_first_strb), .cmd_last_strb(cmd_last_strb),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sent = 0;
  int wlast_idx = 0;
  int err_burst = -1;
  int done_cnt = 0;
  int exp_done = 0;
  logic stall_en = 1'b0;
  logic exp_a_phase = 1'b0;
  logic exp_w_phase = 1'b0;
  logic [15:0] cmd_seq = 16'h0;

  logic [31:0] exp_aw_addr[$];
  logic [7:0]  exp_aw_len[$];
  logic [7:0]  exp_w_strb[$];
  logic        exp_w_last[$];
  logic [63:0] exp_w_data[$];
  int          b_time_q[$];
  logic [1:0]  b_resp_q[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] pattern(input int k);
    return {16'hD00D, cmd_seq, 32'(k)};
  endfunction

  task automatic clearModel();
    exp_aw_addr.delete(); exp_aw_len.delete();
    exp_w_strb.delete();  exp_w_last.delete(); exp_w_data.delete();
    b_time_q.delete();    b_resp_q.delete();
    exp_a_phase = 1'b0;
    exp_w_phase = 1'b0;
  endtask

  // Burst list straight from the rules: min(remaining, 16, room to the next 4 KB page).
  task automatic buildModel(input logic [31:0] addr, input int beats,
                            input logic [7:0] first, input logic [7:0] last);
    logic [31:0] a;
    logic [7:0]  s;
    int rem, room, len, k;
    clearModel();
    a = addr; rem = beats; k = 0;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      len = rem;
      if (len > 16)   len = 16;
      if (len > room) len = room;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(8'(len - 1));
      for (int j = 0; j < len; j++) begin
        s = 8'hFF;
        if (k == 0)         s = s & first;
        if (k == beats - 1) s = s & last;
        exp_w_strb.push_back(s);
        exp_w_last.push_back(j == len - 1);
        exp_w_data.push_back(pattern(k));
        k++;
      end
      a = a + 32'(len * 8);
      rem -= len;
    end
  endtask

  // Drives the AXI slave side and stream source, then checks every handshake against the model.
  always @(negedge clk) begin
    cyc++;
    if (stall_en) begin
      m_awready = 1'($urandom_range(0, 1));
      m_wready  = 1'($urandom_range(0, 1));
      s_valid   = 1'($urandom_range(0, 1));
    end else begin
      m_awready = 1'b1;
      m_wready  = 1'b1;
      s_valid   = 1'b1;
    end
    s_data   = pattern(sent);
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    if (!rst && b_time_q.size() > 0 && b_time_q[0] <= cyc) begin
      m_bvalid = 1'b1;
      m_bresp  = b_resp_q.pop_front();
      void'(b_time_q.pop_front());
    end
    #1;
    if (!rst) begin
      checkOutput("wdata_passthru", m_wdata, s_data);
      checkOutput("awvalid_phase", m_awvalid, exp_a_phase);
      checkOutput("wvalid_phase", m_wvalid, s_valid && exp_w_phase);
      checkOutput("s_ready_phase", s_ready, m_wready && exp_w_phase);
      if (done) done_cnt++;
      if (m_awvalid) begin
        if (exp_aw_addr.size() == 0) begin
          checkOutput("unexpected_aw", 1, 0);
        end else begin
          checkOutput("awaddr", m_awaddr, exp_aw_addr[0]);
          checkOutput("awlen", m_awlen, exp_aw_len[0]);
          checkOutput("awsize", m_awsize, 3'd3);
          checkOutput("awburst", m_awburst, 2'b01);
          if (m_awready) begin
            checkOutput("no_4k_cross", (int'(m_awaddr[11:0]) + (int'(m_awlen) + 1) * 8) <= 4096, 1);
            void'(exp_aw_addr.pop_front());
            void'(exp_aw_len.pop_front());
            exp_a_phase = 1'b0;
            exp_w_phase = 1'b1;
          end
        end
      end else if (m_wvalid && m_wready) begin
        if (exp_w_data.size() == 0) begin
          checkOutput("unexpected_w", 1, 0);
        end else begin
          checkOutput("wdata_order", m_wdata, exp_w_data[0]);
          checkOutput("wstrb", m_wstrb, exp_w_strb[0]);
          checkOutput("wlast", m_wlast, exp_w_last[0]);
          sent++;
          void'(exp_w_data.pop_front());
          void'(exp_w_strb.pop_front());
          if (exp_w_last.pop_front()) begin
            exp_w_phase = 1'b0;
            b_time_q.push_back(cyc + 2);
            b_resp_q.push_back((wlast_idx == err_burst) ? 2'b10 : 2'b00);
            wlast_idx++;
            if (exp_aw_addr.size() > 0) exp_a_phase = 1'b1;
          end
        end
      end
    end
  end

  task automatic startCommand(input logic [31:0] addr, input int beats, input logic [7:0] first,
                              input logic [7:0] last, input int err_b, input logic stall);
    int t;
    cmd_seq++;
    sent = 0;
    wlast_idx = 0;
    err_burst = err_b;
    buildModel(addr, beats, first, last);
    @(negedge clk);
    stall_en       = stall;
    cmd_valid      = 1'b1;
    cmd_addr       = addr;
    cmd_beats      = 10'(beats);
    cmd_first_strb = first;
    cmd_last_strb  = last;
    #2;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk); #2; t++;
    end
    checkOutput("cmd_accept_timeout", t < 100, 1);
    exp_a_phase = (beats != 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    checkOutput("err_cleared_on_accept", err, 0);
    if (beats == 0) checkOutput("zero_beat_done", done, 1);
  endtask

  task automatic finishCommand(input logic expect_err);
    int t;
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk); #2; t++;
    end
    checkOutput("done_timeout", t < 3000, 1);
    exp_done++;
    checkOutput("err_at_done", err, expect_err);
    checkOutput("cmd_ready_at_done", cmd_ready, 0);
    checkOutput("aw_left_at_done", exp_aw_addr.size(), 0);
    checkOutput("w_left_at_done", exp_w_data.size(), 0);
    checkOutput("b_left_at_done", b_time_q.size(), 0);
    @(negedge clk); #2;
    checkOutput("done_single_pulse", done, 0);
    checkOutput("cmd_ready_after_done", cmd_ready, 1);
    checkOutput("done_count", done_cnt, exp_done);
    stall_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input int beats, input logic [7:0] first,
                               input logic [7:0] last, input int err_b, input logic stall,
                               input logic expect_err);
    startCommand(addr, beats, first, last, err_b, stall);
    finishCommand(expect_err);
  endtask

  initial begin
    int t;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    cmd_first_strb = '0; cmd_last_strb = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_awvalid", m_awvalid, 0);
    checkOutput("rst_wvalid", m_wvalid, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_bready", m_bready, 0);
    checkOutput("rst_awaddr", m_awaddr, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #2;
    checkOutput("bready_after_reset", m_bready, 1);

    $display("[TB] 40 beats from 0x1000");
    buildModel(32'h1000, 40, 8'hFF, 8'h0F);
    checkOutput("model_b0_addr", exp_aw_addr[0], 32'h1000);
    checkOutput("model_b1_addr", exp_aw_addr[1], 32'h1080);
    checkOutput("model_b2_addr", exp_aw_addr[2], 32'h1100);
    checkOutput("model_b2_len", exp_aw_len[2], 8'd7);
    checkOutput("model_beat39_strb", exp_w_strb[39], 8'h0F);
    checkOutput("model_beat15_last", exp_w_last[15], 1);
    applyStimulus(32'h1000, 40, 8'hFF, 8'h0F, -1, 1'b0, 1'b0);

    $display("[TB] 6 beats across a 4 KB page");
    buildModel(32'h1FF0, 6, 8'hFF, 8'hFF);
    checkOutput("model_4k_len0", exp_aw_len[0], 8'd1);
    checkOutput("model_4k_addr1", exp_aw_addr[1], 32'h2000);
    checkOutput("model_4k_len1", exp_aw_len[1], 8'd3);
    applyStimulus(32'h1FF0, 6, 8'hFF, 8'hFF, -1, 1'b0, 1'b0);

    $display("[TB] single beat");
    buildModel(32'h3000, 1, 8'hF0, 8'h3C);
    checkOutput("model_single_strb", exp_w_strb[0], 8'h30);
    applyStimulus(32'h3000, 1, 8'hF0, 8'h3C, -1, 1'b0, 1'b0);

    $display("[TB] 33 beats with random stalls");
    applyStimulus(32'h4000, 33, 8'hFE, 8'h7F, -1, 1'b1, 1'b0);

    $display("[TB] error response on the second of three bursts");
    applyStimulus(32'h5000, 48, 8'hFF, 8'hFF, 1, 1'b0, 1'b1);

    $display("[TB] zero-beat command clears err");
    applyStimulus(32'h5800, 0, 8'hFF, 8'hFF, -1, 1'b0, 1'b0);

    $display("[TB] reset during data phase");
    startCommand(32'h6000, 20, 8'hFF, 8'hFF, -1, 1'b0);
    t = 0;
    while (sent < 5 && t < 200) begin
      @(negedge clk); t++;
    end
    checkOutput("reset_wait_timeout", t < 200, 1);
    @(negedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_awvalid", m_awvalid, 0);
    checkOutput("midrst_wvalid", m_wvalid, 0);
    checkOutput("midrst_s_ready", s_ready, 0);
    checkOutput("midrst_wlast", m_wlast, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_bready", m_bready, 0);
    repeat (2) @(negedge clk);
    clearModel();
    rst = 1'b0;
    @(negedge clk); #2;
    checkOutput("cmd_ready_after_midrst", cmd_ready, 1);
    checkOutput("bready_after_midrst", m_bready, 1);
    checkOutput("no_done_on_reset", done_cnt, exp_done);

    $display("[TB] recovery command across a page");
    applyStimulus(32'h0FF8, 3, 8'h0F, 8'hF0, -1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
